// File: rtl/product_accumulator.sv
// Saturating accumulator for a stream of unsigned 32-bit products, with a start/len
// command, valid/ready input handshake and a held result until the consumer takes it.
module product_accumulator #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      prod,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [LEN_W-1:0]   cnt_r, cnt_s;
  logic               ovf_r, ovf_s;
  logic [ACC_W:0]     sat_sum_s;

  // Returns {carry, value}: a carry out of ACC_W bits means the value is pinned at all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [31:0] p);
    logic [ACC_W:0] wide;
    wide = {1'b0, a} + {{(ACC_W+1-32){1'b0}}, p};
    if (wide[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    ovf_s     = ovf_r;
    sat_sum_s = sat_add(acc_r, prod);
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s = {ACC_W{1'b0}};
          ovf_s = 1'b0;
          cnt_s = len;
          if (len == CNT_ZERO) begin
            state_s = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_s = sat_sum_s[ACC_W-1:0];
          ovf_s = ovf_r | sat_sum_s[ACC_W];
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= CNT_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign acc_out   = acc_r;
  assign overflow  = ovf_r;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator width in bits (legal range 33..64).
REQ-002 SHALL have parameter LEN_W, default 8, width of the product-count field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, number of products to accumulate; sampled with start.
REQ-007 SHALL have port in_valid, input, 1, upstream asserts when prod holds a valid product.
REQ-008 SHALL have port in_ready, output, 1, block can accept prod this cycle.
REQ-009 SHALL have port prod, input, 32, unsigned 16x16 product from the upstream multiplier.
REQ-010 SHALL have port acc_out, output, ACC_W, accumulated sum.
REQ-011 SHALL have port out_valid, output, 1, acc_out holds a final result.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port overflow, output, 1, sticky saturation flag for the current result.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DONE; encoding is free.
REQ-016 In IDLE, start=1 with len!=0 SHALL clear acc to 0, clear overflow, load cnt=len and enter ACCUM next cycle.
REQ-017 In IDLE, start=1 with len==0 SHALL clear acc and overflow and enter DONE directly (result 0).
REQ-018 start SHALL be ignored in ACCUM and DONE; len SHALL be ignored when start is not accepted.
REQ-019 in_ready SHALL equal 1 exactly when state==ACCUM; combinationally from state only, independent of in_valid.
REQ-020 A beat SHALL transfer only on a cycle with in_valid=1 and in_ready=1; prod is ignored otherwise.
REQ-021 On each transfer, acc SHALL become acc + zero-extended prod, computed at ACC_W+1 bits.
REQ-022 If that sum exceeds 2^ACC_W-1, acc SHALL saturate to 2^ACC_W-1 and overflow SHALL set; it stays set until the next accepted start or rst.
REQ-023 Once saturated, further transfers SHALL leave acc at 2^ACC_W-1.
REQ-024 Each transfer SHALL decrement cnt; the transfer with cnt==1 SHALL move the state to DONE next cycle.
REQ-025 Latency: out_valid SHALL rise on the cycle after the last transfer; no bubble is required between transfers (one product per cycle throughput).
REQ-026 In DONE, out_valid SHALL be 1 and acc_out and overflow SHALL hold constant until out_ready=1.
REQ-027 In DONE, out_ready=1 SHALL return to IDLE next cycle; start in that same cycle SHALL be ignored.
REQ-028 acc_out SHALL always present the acc register (running sum visible in ACCUM, informational only).
REQ-029 With defaults, ACC_W >= 32+LEN_W, so overflow SHALL never assert for any legal len.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, acc=0, cnt=0, overflow=0; rst has priority over every other input.
REQ-031 During and after reset: in_ready=0, out_valid=0, busy=0, acc_out=0, overflow=0.
REQ-032 rst in ACCUM or DONE SHALL abandon the operation; no result SHALL be emitted for it.

Verification
REQ-033 start, len=3; products 100, 200, 300 on consecutive cycles, out_ready=1 -> out_valid one cycle after third beat, acc_out=600, overflow=0, IDLE next cycle.
REQ-034 start, len=2; in_valid toggles 1,0,0,1 with prod 0xFFFF_FFFF (=65535*65535+...) both beats -> acc_out=0x1_FFFF_FFFE, only valid cycles counted.
REQ-035 start, len=0 -> out_valid next cycle, acc_out=0, in_ready never asserted.
REQ-036 ACC_W=33, len=3, prod 0xFFFF_FFFF x3 -> acc_out=0x1_FFFF_FFFF, overflow=1; next start clears overflow.
REQ-037 out_ready held 0 for 5 cycles in DONE with start pulsed -> acc_out/out_valid stable, start ignored, no new accumulation.
REQ-038 rst asserted after 1 of 4 beats -> next cycle IDLE, acc_out=0, busy=0, in_ready=0; subsequent start, len=1, prod=7 -> acc_out=7.
